// File: rtl/pcie_vc_trans_n.sv
// Transaction-layer buffer/arbiter: each input port is split into NVC virtual-channel
// FIFOs, drained by a per-port round-robin arbiter into a ready/valid output register.
module pcie_vc_trans_n #(
  parameter int NPORTS = 2,
  parameter int NVC    = 2,
  parameter int VC_W   = 1,
  parameter int DATA_W = 5,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NPORTS-1:0]          in_valid,
  input  logic [NPORTS*(VC_W+DATA_W)-1:0] in_data,
  input  logic [CNT_W-1:0]           umbral_alto,
  input  logic [CNT_W-1:0]           umbral_bajo,
  input  logic [NPORTS-1:0]          out_ready,
  output logic [NPORTS-1:0]          out_valid,
  output logic [NPORTS*DATA_W-1:0]   out_data,
  output logic [NPORTS*VC_W-1:0]     out_vc,
  output logic [NPORTS*NVC-1:0]      pause,
  output logic [NPORTS*NVC-1:0]      continue_o,
  output logic [NPORTS*NVC-1:0]      empty,
  output logic [NPORTS*NVC-1:0]      fifo_error
);

  localparam int IW    = VC_W + DATA_W;
  localparam int PTR_W = CNT_W - 1;
  localparam int NF    = NPORTS * NVC;

  // Stage 1: input register
  logic [NPORTS-1:0] in_valid_r;
  logic [VC_W-1:0]   in_vc_r  [NPORTS];
  logic [DATA_W-1:0] in_pay_r [NPORTS];

  // Stage 2: VC FIFOs
  logic [DATA_W-1:0] mem     [NPORTS][NVC][DEPTH];
  logic [CNT_W-1:0]  cnt     [NPORTS][NVC];
  logic [CNT_W-1:0]  cnt_nxt [NPORTS][NVC];
  logic [PTR_W-1:0]  wptr    [NPORTS][NVC];
  logic [PTR_W-1:0]  rptr    [NPORTS][NVC];
  logic              push    [NPORTS][NVC];
  logic              pop     [NPORTS][NVC];
  logic [NF-1:0]     overflow;
  logic [NF-1:0]     pause_nxt;

  // Stage 3: arbitration
  logic [VC_W-1:0]   rr_ptr  [NPORTS];
  logic [VC_W-1:0]   grant   [NPORTS];
  logic [NPORTS-1:0] grant_any;
  logic [NPORTS-1:0] slot_free;
  logic [DATA_W-1:0] rd_data [NPORTS];

  // Round-robin search: first non-empty VC at or after rr_ptr, wrapping modulo NVC.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latches.
    for (int p = 0; p < NPORTS; p++) begin
      slot_free[p] = !out_valid[p] || out_ready[p];
      grant_any[p] = 1'b0;
      grant[p]     = rr_ptr[p];
      for (int i = 0; i < NVC; i++) begin
        if (!grant_any[p] && (cnt[p][VC_W'(rr_ptr[p] + VC_W'(i))] != '0)) begin
          grant_any[p] = 1'b1;
          grant[p]     = VC_W'(rr_ptr[p] + VC_W'(i));
        end
      end
      rd_data[p] = mem[p][grant[p]][rptr[p][grant[p]]];
    end
  end

  // Push/pop decisions and next-state flow control, per FIFO.
  always_comb begin
    overflow  = '0;
    pause_nxt = '0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int v = 0; v < NVC; v++) begin
        logic push_req;
        logic full;
        push_req = in_valid_r[p] && (in_vc_r[p] == VC_W'(v));
        full     = (cnt[p][v] == CNT_W'(DEPTH));
        pop[p][v]  = slot_free[p] && grant_any[p] && (grant[p] == VC_W'(v));
        // A full FIFO still accepts a word when it frees a slot in the same cycle.
        push[p][v] = push_req && (!full || pop[p][v]);
        overflow[p*NVC+v] = push_req && full && !pop[p][v];
        cnt_nxt[p][v] = cnt[p][v] + CNT_W'(push[p][v]) - CNT_W'(pop[p][v]);
        if (cnt_nxt[p][v] >= umbral_alto)
          pause_nxt[p*NVC+v] = 1'b1;
        else if (cnt_nxt[p][v] <= umbral_bajo)
          pause_nxt[p*NVC+v] = 1'b0;
        else
          pause_nxt[p*NVC+v] = pause[p*NVC+v];
      end
    end
  end

  always_comb begin
    empty = '0;
    for (int p = 0; p < NPORTS; p++)
      for (int v = 0; v < NVC; v++)
        empty[p*NVC+v] = (cnt[p][v] == '0);
  end

  // NOTE: payload storage has no reset; the counts and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++)
      for (int v = 0; v < NVC; v++)
        if (push[p][v])
          mem[p][v][wptr[p][v]] <= in_pay_r[p];
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register here sees only pre-edge values.
    if (reset) begin
      in_valid_r <= '0;
      out_valid  <= '0;
      out_data   <= '0;
      out_vc     <= '0;
      pause      <= '0;
      continue_o <= '0;
      fifo_error <= '0;
      for (int p = 0; p < NPORTS; p++) begin
        in_vc_r[p]  <= '0;
        in_pay_r[p] <= '0;
        rr_ptr[p]   <= '0;
        for (int v = 0; v < NVC; v++) begin
          cnt[p][v]  <= '0;
          wptr[p][v] <= '0;
          rptr[p][v] <= '0;
        end
      end
    end else begin
      in_valid_r <= in_valid;
      pause      <= pause_nxt;
      continue_o <= pause & ~pause_nxt;
      fifo_error <= fifo_error | overflow;
      for (int p = 0; p < NPORTS; p++) begin
        {in_vc_r[p], in_pay_r[p]} <= in_data[p*IW +: IW];
        for (int v = 0; v < NVC; v++) begin
          cnt[p][v] <= cnt_nxt[p][v];
          if (push[p][v]) wptr[p][v] <= wptr[p][v] + PTR_W'(1);
          if (pop[p][v])  rptr[p][v] <= rptr[p][v] + PTR_W'(1);
        end
        // A stalled slot (valid && !ready) keeps its word and its arbiter pointer.
        if (slot_free[p]) begin
          if (grant_any[p]) begin
            out_valid[p]                  <= 1'b1;
            out_data[p*DATA_W +: DATA_W]  <= rd_data[p];
            out_vc[p*VC_W +: VC_W]        <= grant[p];
            rr_ptr[p]                     <= grant[p] + VC_W'(1);
          end else begin
            out_valid[p] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pcie_vc_trans_n.sv
// Directed bench for pcie_vc_trans_n: expected words are queued per port when the
// stimulus is issued and a negedge monitor pops them on every output handshake.
module tb_pcie_vc_trans_n;

  localparam int NPORTS = 2;
  localparam int NVC    = 2;
  localparam int VC_W   = 1;
  localparam int DATA_W = 5;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int IW     = VC_W + DATA_W;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NPORTS-1:0]           in_valid;
  logic [NPORTS*IW-1:0]        in_data;
  logic [CNT_W-1:0]            umbral_alto;
  logic [CNT_W-1:0]            umbral_bajo;
  logic [NPORTS-1:0]           out_ready;
  logic [NPORTS-1:0]           out_valid;
  logic [NPORTS*DATA_W-1:0]    out_data;
  logic [NPORTS*VC_W-1:0]      out_vc;
  logic [NPORTS*NVC-1:0]       pause;
  logic [NPORTS*NVC-1:0]       continue_o;
  logic [NPORTS*NVC-1:0]       empty;
  logic [NPORTS*NVC-1:0]       fifo_error;

  int tests    = 0;
  int failures = 0;

  logic [IW-1:0] q0[$];
  logic [IW-1:0] q1[$];

  pcie_vc_trans_n #(
    .NPORTS(NPORTS), .NVC(NVC), .VC_W(VC_W),
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_vc(out_vc),
    .pause(pause), .continue_o(continue_o),
    .empty(empty), .fifo_error(fifo_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; holds the word for exactly one sampling edge.
  task automatic send(input int p, input logic [VC_W-1:0] vc, input logic [DATA_W-1:0] d);
    in_valid[p]          = 1'b1;
    in_data[p*IW +: IW]  = {vc, d};
    tick();
    in_valid[p] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++) tick();
    check("drain_remaining", q0.size() + q1.size(), 0);
  endtask

  // Monitor: every handshake must match the oldest expected word of that port.
  always @(negedge clk) begin
    if (!reset && out_valid[0] && out_ready[0]) begin
      if (q0.size() == 0) check("port0_unexpected", {out_vc[0], out_data[4:0]}, 32'hFFFF);
      else check("port0_word", {out_vc[0], out_data[4:0]}, q0.pop_front());
    end
    if (!reset && out_valid[1] && out_ready[1]) begin
      if (q1.size() == 0) check("port1_unexpected", {out_vc[1], out_data[9:5]}, 32'hFFFF);
      else check("port1_word", {out_vc[1], out_data[9:5]}, q1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    in_valid    = '0;
    in_data     = '0;
    out_ready   = 2'b11;
    umbral_alto = 4'd15;
    umbral_bajo = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    repeat (10) tick();
    check("idle_out_valid", out_valid, 2'b00);
    check("idle_empty", empty, 4'hF);
    check("idle_pause", pause, 4'h0);
    check("idle_error", fifo_error, 4'h0);
    check("idle_continue", continue_o, 4'h0);

    // Two-edge latency, port1 untouched
    q0.push_back({1'b1, 5'h15});
    send(0, 1'b1, 5'h15);
    tick();
    check("latency_early", out_valid[0], 1'b0);
    tick();
    check("latency_valid", out_valid[0], 1'b1);
    check("latency_data", out_data[4:0], 5'h15);
    check("latency_vc", out_vc[0], 1'b1);
    check("latency_port1_idle", out_valid[1], 1'b0);
    wait_drain();

    // Round-robin alternation with output stalled while filling
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q0.push_back({1'b0, 5'(5'h10 + i)});
      q0.push_back({1'b1, 5'(5'h08 + i)});
    end
    for (int i = 0; i < 4; i++) begin
      send(0, 1'b0, 5'(5'h10 + i));
      send(0, 1'b1, 5'(5'h08 + i));
    end
    repeat (3) tick();
    check("rr_stall_held", q0.size(), 8);
    out_ready[0] = 1'b1;
    wait_drain();

    // Pause hysteresis on port1 VC0 (flat index 2)
    umbral_alto  = 4'd6;
    umbral_bajo  = 4'd2;
    out_ready    = 2'b00;
    q1.push_back({1'b1, 5'h1F});
    for (int i = 0; i < 6; i++) q1.push_back({1'b0, 5'(5'h0A + i)});
    send(1, 1'b1, 5'h1F);
    for (int i = 0; i < 5; i++) send(1, 1'b0, 5'(5'h0A + i));
    tick();
    check("pause_at5", pause[2], 1'b0);
    send(1, 1'b0, 5'h0F);
    tick();
    check("pause_at6", pause[2], 1'b1);
    for (int c = 5; c >= 2; c--) begin
      out_ready[1] = 1'b1;
      tick();
      out_ready[1] = 1'b0;
      check($sformatf("pause_drain_%0d", c), pause[2], (c == 2) ? 1'b0 : 1'b1);
      check($sformatf("continue_drain_%0d", c), continue_o[2], (c == 2) ? 1'b1 : 1'b0);
    end
    tick();
    check("continue_one_cycle", continue_o[2], 1'b0);
    check("pause_stays_low", pause[2], 1'b0);
    out_ready[1] = 1'b1;
    wait_drain();
    umbral_alto = 4'd15;
    umbral_bajo = 4'd0;

    // Overflow on port0 VC0: 10 words into 8 slots behind a held output
    out_ready = 2'b00;
    q0.push_back({1'b1, 5'h1E});
    for (int i = 0; i < 8; i++) q0.push_back({1'b0, 5'(5'h01 + i)});
    send(0, 1'b1, 5'h1E);
    for (int i = 0; i < 8; i++) send(0, 1'b0, 5'(5'h01 + i));
    tick();
    check("ovf_before_err", fifo_error[0], 1'b0);
    check("ovf_full_not_empty", empty[0], 1'b0);
    send(0, 1'b0, 5'h09);
    tick();
    check("ovf_err_set", fifo_error[0], 1'b1);
    send(0, 1'b0, 5'h0A);
    tick();
    check("ovf_err_sticky", fifo_error[0], 1'b1);
    check("ovf_other_vc_clean", fifo_error[1], 1'b0);
    out_ready[0] = 1'b1;
    wait_drain();
    repeat (2) tick();
    check("ovf_err_after_drain", fifo_error[0], 1'b1);
    check("ovf_empty_after_drain", empty[0], 1'b1);

    // Asynchronous reset with words buffered; nothing may emerge afterwards
    out_ready[0] = 1'b0;
    send(0, 1'b1, 5'h03);
    for (int i = 0; i < 5; i++) send(0, 1'b0, 5'(5'h11 + i));
    repeat (2) tick();
    check("pre_reset_valid", out_valid[0], 1'b1);
    #3 reset = 1'b1;
    #1;
    check("async_out_valid", out_valid, 2'b00);
    check("async_empty", empty, 4'hF);
    check("async_error_cleared", fifo_error, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 2'b11;
    reset     = 1'b0;
    repeat (10) tick();
    check("post_reset_idle", out_valid, 2'b00);
    q1.push_back({1'b1, 5'h07});
    send(1, 1'b1, 5'h07);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/pcie_vc_trans_n.md
Name: pcie_vc_trans_n

Overview:
- Parametrised transaction-layer buffer/arbiter: NPORTS input ports, each demultiplexed into NVC virtual-channel FIFOs.
- Each output port drains its own port's VC FIFOs through a round-robin arbiter with a ready/valid handshake.
- Per-FIFO flow control: hysteretic pause/continue against programmable thresholds, plus sticky overflow error.
- Successor to the fixed 2-port/2-VC transaction block; adds output backpressure, fair arbitration and an error latch.

Parameters:
- NPORTS, 2, number of input/output port pairs (1..8).
- NVC, 2, virtual channels per port (power of 2, 2..4).
- VC_W, 1, log2(NVC); width of VC select field.
- DATA_W, 5, payload width.
- DEPTH, 8, entries per VC FIFO (power of 2).
- CNT_W, 4, log2(DEPTH)+1; occupancy and threshold width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  NPORTS  per-port input strobe.
- in_data  in  NPORTS*(VC_W+DATA_W)  port p slice [p*(VC_W+DATA_W) +: ...]; upper VC_W bits = VC, lower DATA_W bits = payload.
- umbral_alto  in  CNT_W  pause threshold (high).
- umbral_bajo  in  CNT_W  continue threshold (low).
- out_ready  in  NPORTS  downstream accept per output port.
- out_valid  out  NPORTS  output holds a word.
- out_data  out  NPORTS*DATA_W  payload.
- out_vc  out  NPORTS*VC_W  VC the word came from.
- pause  out  NPORTS*NVC  level; index p*NVC+v.
- continue_o  out  NPORTS*NVC  one-cycle pulse.
- empty  out  NPORTS*NVC  FIFO count==0.
- fifo_error  out  NPORTS*NVC  sticky overflow flag.

Behaviour:
- Reset values:
  - All FIFO counts, read/write pointers and input registers = 0.
  - out_valid, out_data, out_vc, pause, continue_o, fifo_error = 0; empty = all 1.
  - RR pointers = VC0.
  - Reset mid-operation flushes all FIFO contents; no words are emitted afterwards.
- Stage 1 (input register): at each edge, register in_valid[p] and in_data slice. Invalid cycles push nothing; data is don't-care.
- Stage 2 (push): registered valid word is pushed into FIFO[p][vc].
  - Full with no same-cycle pop: word dropped, count unchanged, fifo_error[p*NVC+vc] set. It stays set until reset.
  - Full with same-cycle pop: push accepted, count unchanged, no error.
- Stage 3 (pop/output register):
  - Output slot p is free when out_valid[p]==0 or out_ready[p]==1.
  - If free and any FIFO[p][*] is non-empty: the arbiter grants the first non-empty VC at or after rr_ptr[p] (cyclic order).
  - The granted FIFO is popped; out_data/out_vc/out_valid load at the edge; rr_ptr[p] <= grant+1 mod NVC.
  - If free and all FIFOs of p are empty: out_valid[p] <= 0.
  - If not free (out_valid=1, out_ready=0): out_* held stable, no pop, rr_ptr unchanged.
- Latency: word sampled at edge k with empty FIFO, idle output and ready → out_valid=1 after edge k+2. Sustained throughput is 1 word/cycle/port.
- Pop on empty never occurs; there is no bypass path around a FIFO.
- Flow control per FIFO, evaluated on the post-edge count:
  - pause sets when count >= umbral_alto.
  - pause clears when count <= umbral_bajo.
  - Otherwise pause holds its value (hysteresis).
  - continue_o pulses for exactly one cycle on each 1→0 pause transition.
  - If umbral_bajo >= umbral_alto, pause = (count >= umbral_alto) and continue_o pulses on its fall.
  - umbral_alto == 0 forces pause=1 permanently.
- Thresholds are sampled live; no shadowing.
- Ports are fully independent; no cross-port routing.

Test Plan:
- Reset then idle 10 cycles → all out_valid=0, empty=all 1, pause=0, fifo_error=0.
- Port0 sends VC1 payload 5'h15 at edge k, out_ready=1 → out_valid[0]=1, out_data=5'h15, out_vc=1 after edge k+2. Port1 outputs stay idle.
- Fill both VCs of port0 with 4 words each while out_ready=0, then raise ready → output VC order 0,1,0,1,0,1,0,1; data in FIFO order per VC.
- alto=6, bajo=2, out_ready=0, push 6 words to VC0P1 → pause[2]=1 after the 6th write. Drain to count 2 → pause falls and continue_o[2] pulses for one cycle; it does not pulse at count 3.
- DEPTH=8, out_ready=0, push 10 words to VC0P0 → count=8, fifo_error[0]=1 and stays 1. Drain: exactly the first 8 words appear.
- Assert reset mid-stream with 5 words buffered → outputs clear immediately (asynchronously). After release, out_valid stays 0 until new input arrives.
